// File: rtl/ram_sp_1536x32_arb.sv
// Two-client round-robin arbiter with lock for the 1536x32 single-port RAM.
// Grants are combinational. Read data returns one cycle after the grant. Out-of-range accesses are flagged and never reach the RAM.
module ram_sp_1536x32_arb #(
    parameter int ADR_WD = 11,
    parameter int DAT_WD = 32,
    parameter int DEPTH  = 1536
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c0_req_i,
    input  logic              c0_we_i,
    input  logic              c0_lock_i,
    input  logic [ADR_WD-1:0] c0_adr_i,
    input  logic [DAT_WD-1:0] c0_dat_i,
    output logic              c0_gnt_o,
    output logic              c0_rd_val_o,
    output logic [DAT_WD-1:0] c0_rd_dat_o,
    input  logic              c1_req_i,
    input  logic              c1_we_i,
    input  logic              c1_lock_i,
    input  logic [ADR_WD-1:0] c1_adr_i,
    input  logic [DAT_WD-1:0] c1_dat_i,
    output logic              c1_gnt_o,
    output logic              c1_rd_val_o,
    output logic [DAT_WD-1:0] c1_rd_dat_o,
    output logic [ADR_WD-1:0] ram_adr_o,
    output logic              ram_wr_ena_o,
    output logic [DAT_WD-1:0] ram_wr_dat_o,
    output logic              ram_rd_ena_o,
    input  logic [DAT_WD-1:0] ram_rd_dat_i,
    output logic              err_o,
    output logic [ADR_WD-1:0] err_adr_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} own_t;

    own_t              own_q, own_d;
    logic              pri_q, pri_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic              oor_q, oor_d;
    logic              err_q, err_d;
    logic [ADR_WD-1:0] err_adr_q, err_adr_d;

    logic              gnt0, gnt1, any_gnt;
    logic              sel_we, sel_lock, in_range;
    logic [ADR_WD-1:0] sel_adr;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (own_q)
            OWN0: gnt0 = c0_req_i;
            OWN1: gnt1 = c1_req_i;
            default: begin
                if (c0_req_i && c1_req_i) begin
                    gnt0 = ~pri_q;
                    gnt1 = pri_q;
                end else begin
                    gnt0 = c0_req_i;
                    gnt1 = c1_req_i;
                end
            end
        endcase
    end

    // With no grant the mux rests on client 0; the RAM enables stay low.
    assign any_gnt  = gnt0 | gnt1;
    assign sel_adr  = gnt1 ? c1_adr_i  : c0_adr_i;
    assign sel_we   = gnt1 ? c1_we_i   : c0_we_i;
    assign sel_lock = gnt1 ? c1_lock_i : c0_lock_i;
    assign in_range = {1'b0, sel_adr} < (ADR_WD+1)'(DEPTH);

    assign c0_gnt_o     = gnt0;
    assign c1_gnt_o     = gnt1;
    assign ram_adr_o    = sel_adr;
    assign ram_wr_dat_o = gnt1 ? c1_dat_i : c0_dat_i;
    assign ram_wr_ena_o = any_gnt & sel_we & in_range;
    assign ram_rd_ena_o = any_gnt & ~sel_we & in_range;

    always_comb begin
        pri_d     = any_gnt ? gnt0 : pri_q;
        own_d     = own_q;
        rd_pend_d = {gnt1 & ~sel_we, gnt0 & ~sel_we};
        oor_d     = any_gnt & ~in_range;
        err_d     = any_gnt & ~in_range;
        err_adr_d = err_d ? sel_adr : err_adr_q;
        case (own_q)
            IDLE: if (any_gnt && sel_lock) own_d = gnt0 ? OWN0 : OWN1;
            // The owner releases on an unlocked grant, or when it drops both req and lock.
            OWN0: if (!c0_lock_i && (gnt0 || !c0_req_i)) own_d = IDLE;
            OWN1: if (!c1_lock_i && (gnt1 || !c1_req_i)) own_d = IDLE;
            default: own_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            own_q     <= IDLE;
            pri_q     <= 1'b0;
            rd_pend_q <= 2'b00;
            oor_q     <= 1'b0;
            err_q     <= 1'b0;
            err_adr_q <= '0;
        end else begin
            own_q     <= own_d;
            pri_q     <= pri_d;
            rd_pend_q <= rd_pend_d;
            oor_q     <= oor_d;
            err_q     <= err_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign c0_rd_val_o = rd_pend_q[0];
    assign c1_rd_val_o = rd_pend_q[1];
    assign c0_rd_dat_o = oor_q ? '0 : ram_rd_dat_i;
    assign c1_rd_dat_o = oor_q ? '0 : ram_rd_dat_i;
    assign err_o       = err_q;
    assign err_adr_o   = err_adr_q;
endmodule

// File: tb/tb_ram_sp_1536x32_arb.sv
// Scoreboard bench for ram_sp_1536x32_arb: a behavioural RAM sits behind the DUT.
// An abstract arbiter model predicts the grants and the responses for each following cycle.
module tb_ram_sp_1536x32_arb;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int DEPTH = 1536;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          c0_req = 0, c0_we = 0, c0_lock = 0, c1_req = 0, c1_we = 0, c1_lock = 0;
    logic [AW-1:0] c0_adr = '0, c1_adr = '0;
    logic [DW-1:0] c0_dat = '0, c1_dat = '0;
    logic          c0_gnt, c1_gnt, c0_rd_val, c1_rd_val;
    logic [DW-1:0] c0_rd_dat, c1_rd_dat;
    logic [AW-1:0] ram_adr, err_adr;
    logic          ram_wr_ena, ram_rd_ena, err;
    logic [DW-1:0] ram_wr_dat;
    bit   [DW-1:0] ram_rd_q;

    ram_sp_1536x32_arb #(.ADR_WD(AW), .DAT_WD(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .c0_req_i(c0_req), .c0_we_i(c0_we), .c0_lock_i(c0_lock), .c0_adr_i(c0_adr), .c0_dat_i(c0_dat),
        .c0_gnt_o(c0_gnt), .c0_rd_val_o(c0_rd_val), .c0_rd_dat_o(c0_rd_dat),
        .c1_req_i(c1_req), .c1_we_i(c1_we), .c1_lock_i(c1_lock), .c1_adr_i(c1_adr), .c1_dat_i(c1_dat),
        .c1_gnt_o(c1_gnt), .c1_rd_val_o(c1_rd_val), .c1_rd_dat_o(c1_rd_dat),
        .ram_adr_o(ram_adr), .ram_wr_ena_o(ram_wr_ena), .ram_wr_dat_o(ram_wr_dat),
        .ram_rd_ena_o(ram_rd_ena), .ram_rd_dat_i(ram_rd_q),
        .err_o(err), .err_adr_o(err_adr)
    );

    // Behavioural RAM behind the DUT, with a preload port used during reset.
    bit [DW-1:0] ram_mem [0:2047];
    bit          pl_we = 1'b0;
    bit [AW-1:0] pl_adr = '0;
    bit [DW-1:0] pl_dat = '0;
    always @(posedge clk) begin
        if (pl_we) ram_mem[pl_adr] <= pl_dat;
        else if (ram_wr_ena) ram_mem[ram_adr] <= ram_wr_dat;
        if (ram_rd_ena) ram_rd_q <= ram_mem[ram_adr];
    end

    typedef struct {bit req; bit we; bit lock; bit [AW-1:0] adr; bit [DW-1:0] dat;} rq_t;
    typedef struct {bit v0; bit v1; bit [DW-1:0] d; bit err; bit [AW-1:0] eadr;} exp_t;

    exp_t        exp_q[$];
    bit [DW-1:0] ref_mem [0:DEPTH-1];
    int          m_owner = -1;
    int          m_pri = 0;
    bit [AW-1:0] m_eadr = '0;
    int          last_win = -1;
    int          n_tests = 0;
    int          n_fail = 0;
    rq_t         idle_rq = '{default: 0};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic rq_t mk(input bit we, input bit lock, input int adr, input bit [DW-1:0] dat);
        rq_t r;
        r.req = 1'b1; r.we = we; r.lock = lock; r.adr = AW'(adr); r.dat = dat;
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_owner = -1;
        m_pri = 0;
        m_eadr = '0;
    endtask

    // Drive one cycle, check the combinational outputs and queue next-cycle expectations.
    task automatic cycle(input rq_t a, input rq_t b);
        rq_t  r[2];
        int   win;
        bit   inr;
        exp_t e;
        r[0] = a; r[1] = b;
        @(negedge clk);
        #1;
        c0_req = a.req; c0_we = a.we; c0_lock = a.lock; c0_adr = a.adr; c0_dat = a.dat;
        c1_req = b.req; c1_we = b.we; c1_lock = b.lock; c1_adr = b.adr; c1_dat = b.dat;
        #1;
        if (m_owner >= 0) win = r[m_owner].req ? m_owner : -1;
        else if (a.req && b.req) win = m_pri;
        else if (a.req) win = 0;
        else if (b.req) win = 1;
        else win = -1;
        chk("gnt0", c0_gnt, 64'(win == 0));
        chk("gnt1", c1_gnt, 64'(win == 1));
        e = '{default: 0};
        if (win >= 0) begin
            inr = int'(r[win].adr) < DEPTH;
            chk("ram_wr_ena", ram_wr_ena, 64'(r[win].we && inr));
            chk("ram_rd_ena", ram_rd_ena, 64'(!r[win].we && inr));
            if (inr) chk("ram_adr", ram_adr, r[win].adr);
            if (inr && r[win].we) begin
                chk("ram_wr_dat", ram_wr_dat, r[win].dat);
                ref_mem[r[win].adr] = r[win].dat;
            end
            if (!r[win].we) begin
                if (win == 0) e.v0 = 1'b1; else e.v1 = 1'b1;
                e.d = '0;
                if (inr) e.d = ref_mem[r[win].adr];
            end
            if (!inr) begin
                e.err = 1'b1;
                m_eadr = r[win].adr;
            end
            m_pri = 1 - win;
            if (m_owner < 0 && r[win].lock) m_owner = win;
            else if (m_owner == win && !r[win].lock) m_owner = -1;
        end else begin
            chk("ram_wr_ena_idle", ram_wr_ena, 0);
            chk("ram_rd_ena_idle", ram_rd_ena, 0);
            if (m_owner >= 0 && !r[m_owner].req && !r[m_owner].lock) m_owner = -1;
        end
        e.eadr = m_eadr;
        exp_q.push_back(e);
        last_win = win;
    endtask

    task automatic reset_sync();
        @(negedge clk);
        c0_req = 0; c1_req = 0; c0_lock = 0; c1_lock = 0;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: registered outputs are compared one cycle after the matching grant.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rd_val0", c0_rd_val, e.v0);
            chk("rd_val1", c1_rd_val, e.v1);
            if (e.v0) chk("rd_dat0", c0_rd_dat, e.d);
            if (e.v1) chk("rd_dat1", c1_rd_dat, e.d);
            chk("err", err, e.err);
            chk("err_adr", err_adr, e.eadr);
        end
    end

    initial begin
        rq_t p[2];
        pl_we = 1'b1; pl_adr = AW'(5); pl_dat = 32'hDEADBEEF;
        ref_mem[5] = 32'hDEADBEEF;
        repeat (2) @(negedge clk);
        pl_we = 1'b0;
        chk("rst_rd_val0", c0_rd_val, 0);
        chk("rst_rd_val1", c1_rd_val, 0);
        chk("rst_err", err, 0);
        chk("rst_err_adr", err_adr, 0);
        chk("rst_wr_ena", ram_wr_ena, 0);
        chk("rst_rd_ena", ram_rd_ena, 0);
        rst = 1'b0;

        // Read of the preloaded word.
        cycle(mk(0, 0, 5, 0), idle_rq);
        cycle(idle_rq, idle_rq);

        // Both clients always request: grants alternate starting from c0.
        reset_sync();
        for (int i = 0; i < 4; i++) begin
            cycle(mk(1, 0, 10, $urandom), mk(1, 0, 11, $urandom));
            chk("alternate", last_win, i % 2);
        end

        // c1 locked burst to 100..103 while c0 waits on its write to 201.
        cycle(mk(1, 0, 200, 32'h200), idle_rq);
        for (int i = 0; i < 5; i++) begin
            cycle(mk(1, 0, 201, 32'h201), (i < 4) ? mk(1, i < 3, 100 + i, 32'h100 + i) : idle_rq);
            chk("burst_owner", last_win, (i < 4) ? 1 : 0);
        end

        // Write the top word, read it back right after, then an out-of-range read.
        cycle(mk(1, 0, 1535, 32'h12345678), idle_rq);
        cycle(idle_rq, mk(0, 0, 1535, 0));
        cycle(mk(0, 0, 1536, 0), idle_rq);
        cycle(idle_rq, idle_rq);
        cycle(idle_rq, idle_rq);

        // Reset while a read return is pending: rd_val must drop at once.
        cycle(mk(0, 0, 5, 0), idle_rq);
        cycle(idle_rq, mk(1, 1, 300, 32'h300));
        #1 rst = 1'b1;
        #1 chk("async_rst_rd_val0", c0_rd_val, 0);
        model_reset();
        c0_req = 0; c1_req = 0; c0_lock = 0; c1_lock = 0;
        @(negedge clk) rst = 1'b0;
        cycle(mk(0, 0, 5, 0), mk(0, 0, 6, 0));
        chk("post_rst_first_c0", last_win, 0);

        // Reset while c1 holds a lock and stalls c0.
        cycle(idle_rq, mk(1, 1, 301, 32'h301));
        cycle(mk(0, 0, 7, 0), '{req: 0, we: 0, lock: 1, adr: 0, dat: 0});
        chk("lock_stall", last_win, -1);
        #1 rst = 1'b1;
        #1 model_reset();
        c0_req = 0; c1_req = 0; c0_lock = 0; c1_lock = 0;
        @(negedge clk) rst = 1'b0;
        cycle(mk(0, 0, 7, 0), mk(0, 0, 8, 0));
        chk("lock_released_c0", last_win, 0);

        // Random traffic: each client holds its request until granted.
        p[0] = idle_rq; p[1] = idle_rq;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                if (!p[k].req && $urandom_range(3) != 0) begin
                    p[k].req  = 1'b1;
                    p[k].we   = 1'($urandom_range(1));
                    p[k].lock = ($urandom_range(3) == 0);
                    p[k].dat  = $urandom;
                    case ($urandom_range(7))
                        0:       p[k].adr = AW'(1536 + $urandom_range(511));
                        1, 2:    p[k].adr = AW'($urandom_range(15));
                        default: p[k].adr = AW'($urandom_range(1535));
                    endcase
                end
            end
            cycle(p[0], p[1]);
            if (last_win >= 0) p[last_win] = idle_rq;
        end
        repeat (3) cycle(idle_rq, idle_rq);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
